// File: rtl/ctr_step_sequencer.sv
// rtl/ctr_step_sequencer.sv - queued step-command sequencer driving ct/cn of a 6-bit up/down counter
//
// Accepts "count N steps up/down" commands into a small FIFO and plays each one
// out as a SETUP cycle, N PULSE/GAP pairs, and a one-cycle DONE.
// It also keeps a shadow copy (mirror) of the value the counter should hold.
//
// Optional feature: define SEQ_SAT_EN for saturating mode. In that mode each command
// is trimmed at pop time so the mirror never wraps, and clipped flags the trim.
//
// Ports:
//   clk        rising-edge clock, shared with the counter
//   rst        synchronous active-low reset
//   cmd_valid  command offered
//   cmd_dir    0 = up, 1 = down (same encoding as counter ct)
//   cmd_cnt    number of steps, 0..63
//   cmd_ready  FIFO not full and abort low
//   abort      drop current and queued commands
//   ct         counter direction
//   cn         counter enable, high for one cycle per step
//   mirror     expected counter value
//   busy       FSM not idle, or FIFO non-empty
//   done       one-cycle pulse at command completion
//   clipped    one-cycle pulse with done when the command was trimmed
//   level      FIFO occupancy

module ctr_step_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic                     cmd_dir,
    input  logic [5:0]               cmd_cnt,
    output logic                     cmd_ready,
    input  logic                     abort,
    output logic                     ct,
    output logic                     cn,
    output logic [5:0]               mirror,
    output logic                     busy,
    output logic                     done,
    output logic                     clipped,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state;
    logic           cur_dir;
    logic [5:0]     cur_left;

    logic [6:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           head_dir;
    logic [5:0]     head_cnt;
    logic [5:0]     eff_cnt;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    // Abort takes priority over a simultaneous push; nothing is offered in reset.
    assign cmd_ready = rst && !full && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = rst && !abort && (state == S_IDLE) && !empty;
    assign head_dir  = mem[rd_ptr][6];
    assign head_cnt  = mem[rd_ptr][5:0];
    assign busy      = (state != S_IDLE) || !empty;

`ifdef SEQ_SAT_EN
    logic       cur_trim;
    logic [5:0] room;
    logic       trim;

    // Steps available before the mirror would wrap in the head command's direction.
    always_comb begin
        room    = head_dir ? mirror : (6'd63 - mirror);
        trim    = (head_cnt > room);
        eff_cnt = trim ? room : head_cnt;
    end
`else
    assign eff_cnt = head_cnt;
    assign clipped = 1'b0;
`endif

    // Command FIFO storage; push is already suppressed during reset and abort.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_dir, cmd_cnt};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Step FSM with registered ct/cn/done/clipped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            ct       <= 1'b0;
            cn       <= 1'b0;
            mirror   <= '0;
            done     <= 1'b0;
            cur_dir  <= 1'b0;
            cur_left <= '0;
`ifdef SEQ_SAT_EN
            clipped  <= 1'b0;
            cur_trim <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SEQ_SAT_EN
            clipped <= 1'b0;
`endif
            // A PULSE cycle always lands in the mirror, even when abort arrives on
            // its closing edge, because the counter has already seen cn high.
            if (state == S_PULSE) begin
                mirror   <= cur_dir ? (mirror - 6'd1) : (mirror + 6'd1);
                cur_left <= cur_left - 6'd1;
            end

            if (abort) begin
                state <= S_IDLE;
                cn    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!empty) begin
                            cur_dir  <= head_dir;
                            cur_left <= eff_cnt;
                            ct       <= head_dir;
`ifdef SEQ_SAT_EN
                            cur_trim <= trim;
`endif
                            state    <= S_SETUP;
                        end
                    end
                    S_SETUP, S_GAP: begin
                        // In GAP, cur_left was already decremented by the preceding PULSE.
                        if (cur_left == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
`ifdef SEQ_SAT_EN
                            clipped <= cur_trim;
`endif
                        end else begin
                            state <= S_PULSE;
                            cn    <= 1'b1;
                        end
                    end
                    S_PULSE: begin
                        state <= S_GAP;
                        cn    <= 1'b0;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        cn    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ctr_step_sequencer.sv
// tb/tb_ctr_step_sequencer.sv - self-checking bench for ctr_step_sequencer

module tb_ctr_step_sequencer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [5:0] cmd_cnt;
    logic       cmd_ready;
    logic       abort;
    logic       ct;
    logic       cn;
    logic [5:0] mirror;
    logic       busy;
    logic       done;
    logic       clipped;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    int n_cn   = 0;
    int n_done = 0;
    logic prev_cn = 1'b0;
    logic prev_ct = 1'b0;
    logic saw_full = 1'b0;

    typedef struct {
        logic dir;
        int   cnt;
        int   pulses;
        int   mir;
        logic clip;
    } vec_t;

    vec_t tbl[9];

    ctr_step_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_cnt   (cmd_cnt),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .ct        (ct),
        .cn        (cn),
        .mirror    (mirror),
        .busy      (busy),
        .done      (done),
        .clipped   (clipped),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle monitor: cn spacing, ct stability under cn, pulse/done tallies.
    always begin
        @(posedge clk);
        #1;
        if (rst && cn) begin
            check("cn_spacing_ct_stable", int'(prev_cn || (ct != prev_ct)), 0);
        end
        if (cn)   n_cn++;
        if (done) n_done++;
        prev_cn = cn;
        prev_ct = ct;
    end

    task automatic do_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_wait(input logic dir, input int cnt);
        int k;
        k         = 0;
        cmd_dir   = dir;
        cmd_cnt   = 6'(cnt);
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 300) begin
            if (level == 3'(DEPTH)) saw_full = 1'b1;
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("push_timeout", 1, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 300);
        if (!done) check(name, 0, 1);
    endtask

    initial begin
        int   k, pulses, first_cn, c0, d0;
        logic got, clip_s;
        int   exp_m[4];
        int   exp_p[4];

        tbl[0] = '{1'b0, 4,  4,  4,  1'b0};
        tbl[1] = '{1'b1, 2,  2,  2,  1'b0};
        tbl[2] = '{1'b0, 8,  8,  10, 1'b0};
        tbl[3] = '{1'b1, 6,  6,  4,  1'b0};
        tbl[4] = '{1'b0, 0,  0,  4,  1'b0};
        tbl[5] = '{1'b0, 58, 58, 62, 1'b0};
`ifdef SEQ_SAT_EN
        tbl[6] = '{1'b0, 4,  1,  63, 1'b1};
        tbl[7] = '{1'b1, 63, 63, 0,  1'b0};
        tbl[8] = '{1'b1, 63, 0,  0,  1'b1};
`else
        tbl[6] = '{1'b0, 4,  4,  2,  1'b0};
        tbl[7] = '{1'b1, 2,  2,  0,  1'b0};
        tbl[8] = '{1'b1, 63, 63, 1,  1'b0};
`endif
        exp_m = '{4, 2, 10, 4};
        exp_p = '{4, 2, 8, 6};

        // Reset held 3 cycles with a command offered.
        rst       = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_cnt   = 6'd5;
        repeat (3) @(negedge clk);
        check("rst_ct", int'(ct), 0);
        check("rst_cn", int'(cn), 0);
        check("rst_mirror", int'(mirror), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_clipped", int'(clipped), 0);
        check("rst_level", int'(level), 0);
        cmd_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_level", int'(level), 0);

        // Back-to-back +4 -2 +8 -6.
        c0 = n_cn;
        push_wait(1'b0, 4);
        push_wait(1'b1, 2);
        push_wait(1'b0, 8);
        push_wait(1'b1, 6);
        for (int i = 0; i < 4; i++) begin
            wait_done("b2b_done_timeout");
            check("b2b_mirror", int'(mirror), exp_m[i]);
            check("b2b_pulses", n_cn - c0, exp_p[i]);
            c0 = n_cn;
        end

        // Table-driven single commands.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_wait(tbl[i].dir, tbl[i].cnt);
            k = 0; pulses = 0; first_cn = -1; got = 1'b0; clip_s = 1'b0;
            while (!got && k < 300) begin
                @(negedge clk);
                k++;
                if (cn) begin
                    pulses++;
                    if (first_cn < 0) first_cn = k;
                end
                if (done) begin
                    got    = 1'b1;
                    clip_s = clipped;
                end
            end
            check("row_done_seen", int'(got), 1);
            check("row_latency", k, 2 * tbl[i].pulses + 2);
            check("row_pulses", pulses, tbl[i].pulses);
            check("row_mirror", int'(mirror), tbl[i].mir);
            check("row_clipped", int'(clip_s), int'(tbl[i].clip));
            if (tbl[i].pulses > 0) check("row_first_cn", first_cn, 2);
            @(negedge clk);
            check("row_done_single", int'(done), 0);
            check("row_busy_low", int'(busy), 0);
            check("row_ct", int'(ct), int'(tbl[i].dir));
        end

        // FIFO full: six +1 commands offered back-to-back.
        do_reset();
        saw_full = 1'b0;
        d0 = n_done;
        for (int i = 0; i < 6; i++) push_wait(1'b0, 1);
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("full_idle", int'(busy), 0);
        check("full_seen", int'(saw_full), 1);
        check("full_mirror", int'(mirror), 6);
        check("full_dones", n_done - d0, 6);

        // Abort during the 3rd pulse of +8 with +20 queued.
        do_reset();
        push_wait(1'b0, 8);
        push_wait(1'b0, 20);
        c0 = n_cn;
        k = 0;
        while ((n_cn - c0) < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_pulse3", n_cn - c0, 3);
        d0 = n_done;
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_cnt   = 6'd5;
        @(posedge clk);
        check("abort_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check("abort_mirror", int'(mirror), 3);
        check("abort_level", int'(level), 0);
        check("abort_cn", int'(cn), 0);
        check("abort_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_no_more_cn", n_cn - c0, 3);
        check("abort_mirror_hold", int'(mirror), 3);

        // Same, but with reset instead of abort.
        do_reset();
        push_wait(1'b0, 8);
        push_wait(1'b0, 20);
        c0 = n_cn;
        k = 0;
        while ((n_cn - c0) < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reach_pulse3", n_cn - c0, 3);
        d0 = n_done;
        rst       = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst       = 1'b1;
        check("rstmid_mirror", int'(mirror), 0);
        check("rstmid_level", int'(level), 0);
        check("rstmid_cn", int'(cn), 0);
        check("rstmid_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("rstmid_no_done", n_done - d0, 0);
        check("rstmid_no_more_cn", n_cn - c0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
